// File: rtl/mem_wb_stage.sv
// Memory/writeback stage of the 16-bit pipeline.
// ALU results are written back one cycle after acceptance. Loads and stores
// go out over a req/gnt/rvalid memory handshake, and upstream is stalled
// while the access is in flight.
//
// Handshake: a request is held (o_1_mem_req=1, address/we/wdata stable) from
// the cycle after acceptance until the first rising edge that samples
// i_1_mem_gnt=1. A read then completes on the first edge that samples
// i_1_mem_rvalid=1, which may be the grant edge itself. An rvalid seen
// before the grant is ignored. If the access has not completed after
// TIMEOUT_CYC cycles it is abandoned and or_1_mem_err is set and stays set.
module mem_wb_stage #(
  parameter int REG_WIDTH   = 16,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_1_valid,
  input  logic [REG_WIDTH-1:0] i_R_alu_result,
  input  logic [REG_WIDTH-1:0] i_R_store_data,
  input  logic [REG_WIDTH-1:0] i_R_pcplus,
  input  logic [3:0]           i_4_reg_wr_addr,
  input  logic                 i_1_reg_wr_en,
  input  logic                 i_1_mem_wr_en,
  input  logic                 i_1_mem2reg_sel,
  input  logic                 i_1_mem_addr_sel,
  output logic                 o_1_stall,
  output logic                 o_1_mem_req,
  output logic                 o_1_mem_we,
  output logic [REG_WIDTH-1:0] o_R_mem_addr,
  output logic [REG_WIDTH-1:0] o_R_mem_wdata,
  input  logic                 i_1_mem_gnt,
  input  logic                 i_1_mem_rvalid,
  input  logic [REG_WIDTH-1:0] i_R_mem_rdata,
  output logic [REG_WIDTH-1:0] or_R_wr_data,
  output logic [3:0]           or_4_reg_wr_addr,
  output logic                 or_1_reg_wr_en,
  output logic                 or_1_mem_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  // Counter wide enough to hold TIMEOUT_CYC-1, the last cycle before abort.
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cnt;
  logic [3:0]    cap_dest;
  logic          cap_reg_wr_en;

  logic accept;
  logic is_mem_op;
  logic in_mem;
  logic done_wr;
  logic done_rd;
  logic timeout;

  assign accept    = (state == IDLE) && i_1_valid;
  assign is_mem_op = i_1_mem_wr_en || i_1_mem2reg_sel;
  assign in_mem    = (state == REQ) || (state == WAIT);

  // A store finishes on grant. A read finishes on rvalid once granted,
  // which includes rvalid arriving together with the grant.
  assign done_wr = (state == REQ) && i_1_mem_gnt && o_1_mem_we;
  assign done_rd = ((state == REQ) && i_1_mem_gnt && i_1_mem_rvalid && !o_1_mem_we) ||
                   ((state == WAIT) && i_1_mem_rvalid);

  // Completion in the final cycle takes precedence over the abort.
  assign timeout = in_mem && !done_wr && !done_rd && (cnt == CNT_LAST);

  // Stall and request are decoded from the state register alone, so there
  // is no combinational path from the memory inputs to these outputs.
  assign o_1_stall   = (state != IDLE);
  assign o_1_mem_req = (state == REQ);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept && is_mem_op) state_nxt = REQ;
      end
      REQ: begin
        if (done_wr || done_rd || timeout) state_nxt = IDLE;
        else if (i_1_mem_gnt)              state_nxt = WAIT;
      end
      WAIT: begin
        if (done_rd || timeout) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Request capture, timeout counter, writeback port and sticky error flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_1_mem_we       <= 1'b0;
      o_R_mem_addr     <= '0;
      o_R_mem_wdata    <= '0;
      cap_dest         <= '0;
      cap_reg_wr_en    <= 1'b0;
      cnt              <= '0;
      or_R_wr_data     <= '0;
      or_4_reg_wr_addr <= '0;
      or_1_reg_wr_en   <= 1'b0;
      or_1_mem_err     <= 1'b0;
    end else begin
      // Write enable is a single-cycle pulse unless set again below.
      or_1_reg_wr_en <= 1'b0;

      if (accept && !is_mem_op) begin
        or_R_wr_data     <= i_R_alu_result;
        or_4_reg_wr_addr <= i_4_reg_wr_addr;
        or_1_reg_wr_en   <= i_1_reg_wr_en;
      end

      if (accept && is_mem_op) begin
        o_R_mem_addr  <= i_1_mem_addr_sel ? i_R_pcplus : i_R_alu_result;
        o_R_mem_wdata <= i_R_store_data;
        o_1_mem_we    <= i_1_mem_wr_en;
        cap_dest      <= i_4_reg_wr_addr;
        // A store never writes back, even if mem2reg_sel is also set.
        cap_reg_wr_en <= i_1_reg_wr_en && !i_1_mem_wr_en;
        cnt           <= '0;
      end else if (in_mem) begin
        cnt <= cnt + CW'(1);
      end

      if (done_rd) begin
        or_R_wr_data     <= i_R_mem_rdata;
        or_4_reg_wr_addr <= cap_dest;
        or_1_reg_wr_en   <= cap_reg_wr_en;
      end

      if (timeout) begin
        or_1_mem_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Testbench for mem_wb_stage.
// Main instance uses TIMEOUT_CYC=6. A second instance with TIMEOUT_CYC=4
// covers the short-timeout scenario on its own inputs.
module tb_mem_wb_stage;

  localparam int W  = 16;
  localparam int TO = 6;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- main DUT signals ----------------
  logic         i_1_valid = 1'b0;
  logic [W-1:0] i_R_alu_result = '0;
  logic [W-1:0] i_R_store_data = '0;
  logic [W-1:0] i_R_pcplus = '0;
  logic [3:0]   i_4_reg_wr_addr = '0;
  logic         i_1_reg_wr_en = 1'b0;
  logic         i_1_mem_wr_en = 1'b0;
  logic         i_1_mem2reg_sel = 1'b0;
  logic         i_1_mem_addr_sel = 1'b0;
  logic         i_1_mem_gnt = 1'b0;
  logic         i_1_mem_rvalid = 1'b0;
  logic [W-1:0] i_R_mem_rdata = '0;
  logic         o_1_stall;
  logic         o_1_mem_req;
  logic         o_1_mem_we;
  logic [W-1:0] o_R_mem_addr;
  logic [W-1:0] o_R_mem_wdata;
  logic [W-1:0] or_R_wr_data;
  logic [3:0]   or_4_reg_wr_addr;
  logic         or_1_reg_wr_en;
  logic         or_1_mem_err;

  mem_wb_stage #(.REG_WIDTH(W), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst),
    .i_1_valid(i_1_valid), .i_R_alu_result(i_R_alu_result),
    .i_R_store_data(i_R_store_data), .i_R_pcplus(i_R_pcplus),
    .i_4_reg_wr_addr(i_4_reg_wr_addr), .i_1_reg_wr_en(i_1_reg_wr_en),
    .i_1_mem_wr_en(i_1_mem_wr_en), .i_1_mem2reg_sel(i_1_mem2reg_sel),
    .i_1_mem_addr_sel(i_1_mem_addr_sel),
    .o_1_stall(o_1_stall), .o_1_mem_req(o_1_mem_req), .o_1_mem_we(o_1_mem_we),
    .o_R_mem_addr(o_R_mem_addr), .o_R_mem_wdata(o_R_mem_wdata),
    .i_1_mem_gnt(i_1_mem_gnt), .i_1_mem_rvalid(i_1_mem_rvalid),
    .i_R_mem_rdata(i_R_mem_rdata),
    .or_R_wr_data(or_R_wr_data), .or_4_reg_wr_addr(or_4_reg_wr_addr),
    .or_1_reg_wr_en(or_1_reg_wr_en), .or_1_mem_err(or_1_mem_err)
  );

  // ---------------- short-timeout DUT ----------------
  logic         t4_valid = 1'b0;
  logic         t4_load = 1'b0;
  logic [W-1:0] t4_alu = '0;
  logic [3:0]   t4_dest = '0;
  logic         t4_stall, t4_mem_req, t4_mem_we, t4_wr_en, t4_err;
  logic [W-1:0] t4_mem_addr, t4_mem_wdata, t4_wr_data;
  logic [3:0]   t4_wr_addr;

  mem_wb_stage #(.REG_WIDTH(W), .TIMEOUT_CYC(4)) dut4 (
    .clk(clk), .rst(rst),
    .i_1_valid(t4_valid), .i_R_alu_result(t4_alu),
    .i_R_store_data(16'h0000), .i_R_pcplus(16'h0000),
    .i_4_reg_wr_addr(t4_dest), .i_1_reg_wr_en(1'b1),
    .i_1_mem_wr_en(1'b0), .i_1_mem2reg_sel(t4_load),
    .i_1_mem_addr_sel(1'b0),
    .o_1_stall(t4_stall), .o_1_mem_req(t4_mem_req), .o_1_mem_we(t4_mem_we),
    .o_R_mem_addr(t4_mem_addr), .o_R_mem_wdata(t4_mem_wdata),
    .i_1_mem_gnt(1'b0), .i_1_mem_rvalid(1'b0), .i_R_mem_rdata(16'h0000),
    .or_R_wr_data(t4_wr_data), .or_4_reg_wr_addr(t4_wr_addr),
    .or_1_reg_wr_en(t4_wr_en), .or_1_mem_err(t4_err)
  );

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;
  logic [19:0] exp_q[$];   // expected register writes: {addr, data}
  bit err_model = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Every register-file write must match the oldest expected write.
  always @(negedge clk) begin
    if (!rst && or_1_reg_wr_en) begin
      if (exp_q.size() == 0) begin
        check("unexpected_wr", {12'h0, or_4_reg_wr_addr, or_R_wr_data}, 32'hFFFF_FFFF);
      end else begin
        check("wr_addr_data", {12'h0, or_4_reg_wr_addr, or_R_wr_data}, {12'h0, exp_q.pop_front()});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic alu_op(input logic [3:0] dest, input logic [W-1:0] data, input bit wen);
    check("alu_pre_stall", o_1_stall, 0);
    i_1_valid        = 1'b1;
    i_R_alu_result   = data;
    i_4_reg_wr_addr  = dest;
    i_1_reg_wr_en    = wen;
    i_1_mem_wr_en    = 1'b0;
    i_1_mem2reg_sel  = 1'b0;
    i_1_mem_addr_sel = 1'($urandom_range(0, 1));
    i_R_store_data   = W'($urandom);
    i_R_pcplus       = W'($urandom);
    if (wen) exp_q.push_back({dest, data});
    @(negedge clk);
    check("alu_pulse", or_1_reg_wr_en, wen);
    check("alu_stall", o_1_stall, 0);
    check("alu_req", o_1_mem_req, 0);
  endtask

  task automatic idle_cycle();
    i_1_valid = 1'b0;
    @(negedge clk);
    check("idle_nowr", or_1_reg_wr_en, 0);
  endtask

  // One memory transaction. gd = cycles of request before grant,
  // rd = further cycles until rvalid (loads). The access completes in
  // REQ/WAIT cycle index c; if c >= TO it is abandoned after TO cycles.
  task automatic mem_op(input bit store, input bit sel, input logic [W-1:0] alu,
                        input logic [W-1:0] pc, input logic [W-1:0] sdata,
                        input logic [W-1:0] rdata, input logic [3:0] dest,
                        input bit wen, input int gd, input int rd);
    int c, end_k;
    bit to, load, pulse;
    logic [W-1:0] exp_addr;
    load     = !store;
    c        = store ? gd : gd + rd;
    to       = (c >= TO);
    end_k    = to ? TO - 1 : c;
    exp_addr = sel ? pc : alu;
    pulse    = load && !to && wen;
    check("mem_pre_stall", o_1_stall, 0);
    i_1_valid        = 1'b1;
    i_R_alu_result   = alu;
    i_R_pcplus       = pc;
    i_R_store_data   = sdata;
    i_4_reg_wr_addr  = dest;
    i_1_reg_wr_en    = wen;
    i_1_mem_wr_en    = store;
    i_1_mem2reg_sel  = store ? 1'($urandom_range(0, 1)) : 1'b1;
    i_1_mem_addr_sel = sel;
    if (pulse) exp_q.push_back({dest, rdata});
    @(negedge clk);
    for (int k = 0; k <= end_k; k++) begin
      check("busy_stall", o_1_stall, 1);
      check("busy_req", o_1_mem_req, (k <= gd) ? 1 : 0);
      check("busy_nowr", or_1_reg_wr_en, 0);
      if (k <= gd) begin
        check("req_addr", o_R_mem_addr, exp_addr);
        check("req_we", o_1_mem_we, store);
        if (store) check("req_wdata", o_R_mem_wdata, sdata);
      end
      i_1_mem_gnt = (k == gd);
      if (load && k == c) begin
        i_1_mem_rvalid = 1'b1;
        i_R_mem_rdata  = rdata;
      end else if (k < gd) begin
        i_1_mem_rvalid = 1'b1;            // spurious, must be ignored before grant
        i_R_mem_rdata  = W'($urandom);
      end else begin
        i_1_mem_rvalid = 1'b0;
        i_R_mem_rdata  = W'($urandom);
      end
      // Junk instructions offered during the stall must be ignored.
      i_1_valid        = 1'($urandom_range(0, 1));
      i_R_alu_result   = W'($urandom);
      i_4_reg_wr_addr  = 4'($urandom);
      i_1_reg_wr_en    = 1'b1;
      i_1_mem_wr_en    = 1'($urandom_range(0, 1));
      i_1_mem2reg_sel  = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    i_1_mem_gnt    = 1'b0;
    i_1_mem_rvalid = 1'b0;
    i_1_valid      = 1'b0;
    if (to) err_model = 1'b1;
    check("end_stall", o_1_stall, 0);
    check("end_req", o_1_mem_req, 0);
    check("end_pulse", or_1_reg_wr_en, pulse);
    check("end_err", or_1_mem_err, err_model);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_stall"}, o_1_stall, 0);
    check({tag, "_req"}, o_1_mem_req, 0);
    check({tag, "_we"}, o_1_mem_we, 0);
    check({tag, "_maddr"}, o_R_mem_addr, 0);
    check({tag, "_wdata"}, o_R_mem_wdata, 0);
    check({tag, "_wrdata"}, or_R_wr_data, 0);
    check({tag, "_wraddr"}, or_4_reg_wr_addr, 0);
    check({tag, "_wren"}, or_1_reg_wr_en, 0);
    check({tag, "_err"}, or_1_mem_err, 0);
  endtask

  // Safety net against a hang.
  initial begin
    #400000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    // Reset state.
    #12;
    check_all_zero("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // ALU burst, then idle.
    alu_op(4'd1, 16'h0011, 1'b1);
    alu_op(4'd2, 16'h0022, 1'b1);
    alu_op(4'd3, 16'h0033, 1'b1);
    check("burst_data", or_R_wr_data, 16'h0033);
    idle_cycle();

    // Load with waits: completes in the last cycle before timeout.
    mem_op(1'b0, 1'b0, 16'h0040, 16'h9999, 16'h5555, 16'hBEEF, 4'd5, 1'b1, 2, 3);
    check("load_data", or_R_wr_data, 16'hBEEF);
    check("load_addr", or_4_reg_wr_addr, 4'd5);
    idle_cycle();

    // Zero-wait store from pcplus.
    mem_op(1'b1, 1'b1, 16'h7777, 16'h0100, 16'h1234, 16'h0000, 4'd6, 1'b1, 0, 0);
    idle_cycle();

    // Zero-wait load with gnt+rvalid together; one stall cycle.
    mem_op(1'b0, 1'b0, 16'h0200, 16'h0000, 16'h0000, 16'h0007, 4'd15, 1'b1, 0, 0);
    // Same-cycle gnt+rvalid after spurious rvalids during the request.
    mem_op(1'b0, 1'b1, 16'h0000, 16'h0300, 16'h0000, 16'h0A0A, 4'd4, 1'b1, 3, 0);
    // Read timing out in WAIT after the grant.
    mem_op(1'b0, 1'b0, 16'h0400, 16'h0000, 16'h0000, 16'hDEAD, 4'd8, 1'b1, 2, 4);
    alu_op(4'd9, 16'hCAFE, 1'b1);
    check("err_sticky", or_1_mem_err, 1);
    idle_cycle();

    // Reset in the middle of WAIT, off the clock edge.
    i_1_valid = 1'b1; i_1_mem_wr_en = 1'b0; i_1_mem2reg_sel = 1'b1;
    i_R_alu_result = 16'h0500; i_4_reg_wr_addr = 4'd10; i_1_reg_wr_en = 1'b1;
    @(negedge clk);
    i_1_valid = 1'b0; i_1_mem_gnt = 1'b1;
    @(negedge clk);
    i_1_mem_gnt = 1'b0;
    check("pre_rst_wait_stall", o_1_stall, 1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 check_all_zero("midrst");
    err_model = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    i_1_mem_rvalid = 1'b1; i_R_mem_rdata = 16'h4321;
    @(negedge clk);
    i_1_mem_rvalid = 1'b0;
    check("post_rst_nowr", or_1_reg_wr_en, 0);
    check("post_rst_stall", o_1_stall, 0);

    // Short-timeout instance: grant never comes.
    t4_valid = 1'b1; t4_load = 1'b1; t4_alu = 16'h0080; t4_dest = 4'd7;
    @(negedge clk);
    t4_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check("t4_req", t4_mem_req, 1);
      check("t4_stall", t4_stall, 1);
      check("t4_err_early", t4_err, 0);
      check("t4_addr", t4_mem_addr, 16'h0080);
      @(negedge clk);
    end
    check("t4_req_drop", t4_mem_req, 0);
    check("t4_nowr", t4_wr_en, 0);
    check("t4_err_set", t4_err, 1);
    t4_valid = 1'b1; t4_load = 1'b0; t4_alu = 16'h5A5A; t4_dest = 4'd3;
    @(negedge clk);
    t4_valid = 1'b0;
    check("t4_alu_pulse", t4_wr_en, 1);
    check("t4_alu_data", t4_wr_data, 16'h5A5A);
    check("t4_alu_addr", t4_wr_addr, 4'd3);
    @(negedge clk);
    check("t4_err_hold", t4_err, 1);
    check("t4_idle_nowr", t4_wr_en, 0);

    // Randomized mix on the main instance.
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 2))
        0: begin
          int len;
          len = $urandom_range(1, 3);
          for (int j = 0; j < len; j++)
            alu_op(4'($urandom), W'($urandom), 1'($urandom_range(0, 1)));
        end
        1: mem_op(1'b0, 1'($urandom_range(0, 1)), W'($urandom), W'($urandom), W'($urandom),
                  W'($urandom), 4'($urandom), 1'($urandom_range(0, 3) != 0),
                  $urandom_range(0, 4), $urandom_range(0, 4));
        default: mem_op(1'b1, 1'($urandom_range(0, 1)), W'($urandom), W'($urandom), W'($urandom),
                        W'($urandom), 4'($urandom), 1'($urandom_range(0, 1)),
                        $urandom_range(0, 7), 0);
      endcase
      if ($urandom_range(0, 1) == 1) idle_cycle();
    end

    // Drain and final report.
    idle_cycle();
    idle_cycle();
    check("exp_q_empty", exp_q.size(), 0);
    check("final_err", or_1_mem_err, err_model);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
